// File: rtl/music_sequencer.sv
// Two-channel note sequencer for the Buzzer/Speaker_CTL chain.
// Walks a packed note pattern at a programmable tempo (play/pause/stop/loop)
// and overlays timed, prioritised sound effects on the right channel.
// Outputs are divider values for the Buzzer; a divider of 0 means silence.
module music_sequencer #(
   parameter int                    DIV_W      = 27,
   parameter int                    SEQ_LEN    = 16,
   // Step 0 sits in the MSBs; each step is {left_code[4:0], right_code[4:0]}.
   // The default is every step resting (code 0x10 on both channels).
   parameter logic [SEQ_LEN*10-1:0] SEQ        = {SEQ_LEN{10'h210}},
   parameter int                    TICK_DIV   = 100000000,
   parameter int                    SFX_CYCLES = 25000000,
   parameter int                    IDX_W      = $clog2(SEQ_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   input  logic             loop_en,
   input  logic             sfx_die,
   input  logic             sfx_shoot,
   output logic [DIV_W-1:0] div_left,
   output logic [DIV_W-1:0] div_right,
   output logic [1:0]       state,
   output logic [IDX_W-1:0] step_idx,
   output logic             sfx_active
);

   // ------------------------------------------------------------------
   // Derived widths and constants
   // ------------------------------------------------------------------
   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SFX_W  = $clog2(SFX_CYCLES + 1);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SEQ_LEN - 1);
   localparam logic [SFX_W-1:0]  SFX_LOAD  = SFX_W'(SFX_CYCLES);

   // Effect tones: robot death plays m_Do, a shot plays Re.
   localparam logic [DIV_W-1:0] DIV_SFX_DIE   = DIV_W'(45086);
   localparam logic [DIV_W-1:0] DIV_SFX_SHOOT = DIV_W'(170648);

   // Effect priorities; 0 means "no effect".
   localparam logic [1:0] PRI_NONE  = 2'd0;
   localparam logic [1:0] PRI_SHOOT = 2'd1;
   localparam logic [1:0] PRI_DIE   = 2'd2;

   // Transport states; the encoding is visible on the state output.
   typedef enum logic [1:0] {
      ST_STOP  = 2'b00,
      ST_PLAY  = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } seq_state_t;

   // ------------------------------------------------------------------
   // Note code to divider lookup; codes 0x10..0x1F are rests.
   // ------------------------------------------------------------------
   function automatic logic [DIV_W-1:0] note_div(input logic [4:0] code);
      logic [17:0] val;
      case (code)
         5'h00:   val = 18'd191571;  // Do
         5'h01:   val = 18'd170648;  // Re
         5'h02:   val = 18'd151515;  // Mi
         5'h03:   val = 18'd143266;  // Fa
         5'h04:   val = 18'd127551;  // So
         5'h05:   val = 18'd113636;  // La
         5'h06:   val = 18'd101214;  // Si
         5'h07:   val = 18'd45086;   // m_Do
         5'h08:   val = 18'd47081;   // m_Re
         5'h09:   val = 18'd50607;   // m_Mi
         5'h0A:   val = 18'd56818;   // m_Fa
         5'h0B:   val = 18'd63776;   // m_So
         5'h0C:   val = 18'd71633;   // m_La
         5'h0D:   val = 18'd75758;   // m_Si
         5'h0E:   val = 18'd85034;   // H_Do
         5'h0F:   val = 18'd95420;   // H_Re
         default: val = 18'd0;       // rest
      endcase
      return DIV_W'(val);
   endfunction

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   seq_state_t        st_q,   st_d;
   logic [IDX_W-1:0]  step_q, step_d;
   logic [TICK_W-1:0] tick_q, tick_d;

   logic [SFX_W-1:0]  sfx_timer_q, sfx_timer_d;
   logic              sfx_die_q,   sfx_die_d;   // latched effect: 1 = die, 0 = shoot

   logic [9:0]        cur_step;
   logic [DIV_W-1:0]  music_left, music_right;
   logic [1:0]        req_pri, act_pri;
   logic              sounding;

   // ------------------------------------------------------------------
   // Transport FSM
   // ------------------------------------------------------------------

   // Transport state register: state, step index and tempo counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q   <= ST_STOP;
         step_q <= '0;
         tick_q <= '0;
      end else begin
         st_q   <= st_d;
         step_q <= step_d;
         tick_q <= tick_d;
      end
   end

   // Next transport state: stop beats start beats pause; the tempo counter only runs in PLAY.
   always_comb begin
      st_d   = st_q;
      step_d = step_q;
      tick_d = tick_q;
      if (stop) begin
         st_d   = ST_STOP;
         step_d = '0;
         tick_d = '0;
      end else if (start && (st_q != ST_PLAY)) begin
         st_d = ST_PLAY;
         // Resuming from PAUSE keeps position and tick; otherwise rewind.
         if (st_q != ST_PAUSE) begin
            step_d = '0;
            tick_d = '0;
         end
      end else if (pause && (st_q == ST_PLAY)) begin
         st_d = ST_PAUSE;
      end else if (st_q == ST_PLAY) begin
         if (tick_q == TICK_LAST) begin
            // Beat: advance, wrap, or finish; loop_en only matters here.
            tick_d = '0;
            if (step_q != IDX_LAST) begin
               step_d = step_q + 1'b1;
            end else if (loop_en) begin
               step_d = '0;
            end else begin
               st_d = ST_DONE;
            end
         end else begin
            tick_d = tick_q + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Effect overlay
   // ------------------------------------------------------------------
   assign sounding = (sfx_timer_q != '0);

   // Effect arbitration: an equal or higher priority request (re)loads the timer, others are dropped.
   always_comb begin
      sfx_timer_d = sfx_timer_q;
      sfx_die_d   = sfx_die_q;
      req_pri     = sfx_die ? PRI_DIE : (sfx_shoot ? PRI_SHOOT : PRI_NONE);
      act_pri     = sounding ? (sfx_die_q ? PRI_DIE : PRI_SHOOT) : PRI_NONE;
      if ((req_pri != PRI_NONE) && (req_pri >= act_pri)) begin
         sfx_timer_d = SFX_LOAD;
         sfx_die_d   = (req_pri == PRI_DIE);
      end else if (sounding) begin
         sfx_timer_d = sfx_timer_q - 1'b1;
      end
   end

   // Effect timer and latched effect kind; runs in every transport state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sfx_timer_q <= '0;
         sfx_die_q   <= 1'b0;
      end else begin
         sfx_timer_q <= sfx_timer_d;
         sfx_die_q   <= sfx_die_d;
      end
   end

   // ------------------------------------------------------------------
   // Divider outputs
   // ------------------------------------------------------------------

   // Pick out the current step from the packed pattern (step 0 at the MSBs).
   always_comb begin
      cur_step = '0;
      for (int i = 0; i < SEQ_LEN; i++) begin
         if (step_q == IDX_W'(i)) begin
            cur_step = SEQ[(SEQ_LEN-1-i)*10 +: 10];
         end
      end
   end

   // Music tones: PLAY and PAUSE sound the current step, STOP and DONE are silent.
   always_comb begin
      music_left  = '0;
      music_right = '0;
      if ((st_q == ST_PLAY) || (st_q == ST_PAUSE)) begin
         music_left  = note_div(cur_step[9:5]);
         music_right = note_div(cur_step[4:0]);
      end
   end

   // Registered dividers; an active effect replaces only the right channel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_left  <= '0;
         div_right <= '0;
      end else begin
         div_left <= music_left;
         if (sounding) begin
            div_right <= sfx_die_q ? DIV_SFX_DIE : DIV_SFX_SHOOT;
         end else begin
            div_right <= music_right;
         end
      end
   end

   assign state      = st_q;
   assign step_idx   = step_q;
   assign sfx_active = sounding;

   // ------------------------------------------------------------------
   // Structural invariants
   // ------------------------------------------------------------------
   a_step_in_range: assert property (@(posedge clk) disable iff (!rst)
      step_q <= IDX_LAST);
   a_tick_in_range: assert property (@(posedge clk) disable iff (!rst)
      tick_q <= TICK_LAST);
   a_done_at_end: assert property (@(posedge clk) disable iff (!rst)
      (st_q == ST_DONE) |-> (step_q == IDX_LAST));
   a_stop_rewound: assert property (@(posedge clk) disable iff (!rst)
      (st_q == ST_STOP) |-> (step_q == '0));

endmodule

// File: tb/tb_music_sequencer.sv
// Testbench for music_sequencer: directed walk through the transport and
// effect behaviour with literal expectations, followed by randomized
// control/effect traffic, all checked every cycle against a behavioural model.
module tb_music_sequencer;

  localparam int DIV_W      = 27;
  localparam int SEQ_LEN    = 3;
  localparam int TICK_DIV   = 4;
  localparam int SFX_CYCLES = 5;
  localparam int IDX_W      = 2;
  localparam logic [SEQ_LEN*10-1:0] SEQ = {5'h00, 5'h10, 5'h01, 5'h02, 5'h0E, 5'h0F};
  localparam int W = 2 + IDX_W + 1 + 2 * DIV_W;

  logic             clk;
  logic             rst;
  logic             start;
  logic             pause;
  logic             stop;
  logic             loop_en;
  logic             sfx_die;
  logic             sfx_shoot;
  logic [DIV_W-1:0] div_left;
  logic [DIV_W-1:0] div_right;
  logic [1:0]       state;
  logic [IDX_W-1:0] step_idx;
  logic             sfx_active;

  int checks   = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  music_sequencer #(
    .DIV_W     (DIV_W),
    .SEQ_LEN   (SEQ_LEN),
    .SEQ       (SEQ),
    .TICK_DIV  (TICK_DIV),
    .SFX_CYCLES(SFX_CYCLES),
    .IDX_W     (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .loop_en   (loop_en),
    .sfx_die   (sfx_die),
    .sfx_shoot (sfx_shoot),
    .div_left  (div_left),
    .div_right (div_right),
    .state     (state),
    .step_idx  (step_idx),
    .sfx_active(sfx_active)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // mode: 0 stop, 1 play, 2 pause, 3 done
  int m_mode, m_idx, m_tick, m_sfx_left, m_sfx_kind, m_dl, m_dr;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  function automatic int note_val(input int code);
    case (code)
      0: return 191571;  1: return 170648;  2: return 151515;  3: return 143266;
      4: return 127551;  5: return 113636;  6: return 101214;  7: return 45086;
      8: return 47081;   9: return 50607;   10: return 56818;  11: return 63776;
      12: return 71633;  13: return 75758;  14: return 85034;  15: return 95420;
      default: return 0;
    endcase
  endfunction

  // Pattern from the test plan: {0,rest} {Re,Mi} {H_Do,H_Re}
  function automatic int pat_left(input int i);
    case (i)
      0: return 'h00;
      1: return 'h01;
      default: return 'h0E;
    endcase
  endfunction

  function automatic int pat_right(input int i);
    case (i)
      0: return 'h10;
      1: return 'h02;
      default: return 'h0F;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_tick = 0;
    m_sfx_left = 0; m_sfx_kind = 0;
    m_dl = 0; m_dr = 0;
  endtask

  task automatic model_step();
    int music_l, music_r, req, act;
    // dividers reflect the state before this edge
    if (m_mode == 1 || m_mode == 2) begin
      music_l = note_val(pat_left(m_idx));
      music_r = note_val(pat_right(m_idx));
    end else begin
      music_l = 0;
      music_r = 0;
    end
    m_dl = music_l;
    if (m_sfx_left > 0) m_dr = (m_sfx_kind == 2) ? 45086 : 170648;
    else                m_dr = music_r;
    // effects
    req = sfx_die ? 2 : (sfx_shoot ? 1 : 0);
    act = (m_sfx_left > 0) ? m_sfx_kind : 0;
    if (req > 0 && req >= act) begin
      m_sfx_left = SFX_CYCLES;
      m_sfx_kind = req;
    end else if (m_sfx_left > 0) begin
      m_sfx_left = m_sfx_left - 1;
    end
    // transport
    if (stop) begin
      m_mode = 0; m_idx = 0; m_tick = 0;
    end else if (start && m_mode != 1) begin
      if (m_mode != 2) begin
        m_idx = 0; m_tick = 0;
      end
      m_mode = 1;
    end else if (pause && m_mode == 1) begin
      m_mode = 2;
    end else if (m_mode == 1) begin
      if (m_tick == TICK_DIV - 1) begin
        m_tick = 0;
        if (m_idx < SEQ_LEN - 1) m_idx = m_idx + 1;
        else if (loop_en)        m_idx = 0;
        else                     m_mode = 3;
      end else begin
        m_tick = m_tick + 1;
      end
    end
  endtask

  function automatic logic [W-1:0] pack_exp();
    logic [1:0]       f_st;
    logic [IDX_W-1:0] f_idx;
    logic [DIV_W-1:0] f_dl, f_dr;
    f_st  = m_mode[1:0];
    f_idx = m_idx[IDX_W-1:0];
    f_dl  = m_dl[DIV_W-1:0];
    f_dr  = m_dr[DIV_W-1:0];
    return {f_st, f_idx, (m_sfx_left > 0), f_dl, f_dr};
  endfunction

  // asynchronous reset clears the model and any pending expectation at once
  always @(negedge rst) begin
    model_reset();
    exp_q.delete();
    if (clk) exp_q.push_back('0);
  end

  always @(posedge clk) begin
    if (!rst) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      model_step();
      exp_q.push_back(pack_exp());
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 64'd1, 64'd0);
      end else begin
        exp_v = exp_q.pop_front();
        check("state",      64'(state),      64'(exp_v[W-1 -: 2]));
        check("step_idx",   64'(step_idx),   64'(exp_v[W-3 -: IDX_W]));
        check("sfx_active", 64'(sfx_active), 64'(exp_v[2*DIV_W]));
        check("div_left",   64'(div_left),   64'(exp_v[2*DIV_W-1 -: DIV_W]));
        check("div_right",  64'(div_right),  64'(exp_v[DIV_W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Advance to 2 time units after the next rising edge; inputs change here.
  task automatic step_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    start = 1'b0; pause = 1'b0; stop = 1'b0;
    sfx_die = 1'b0; sfx_shoot = 1'b0;
  endtask

  task automatic rand_cycle();
    start     = ($urandom_range(0, 14) == 0);
    pause     = ($urandom_range(0, 19) == 0);
    stop      = ($urandom_range(0, 59) == 0);
    sfx_die   = ($urandom_range(0, 39) == 0);
    sfx_shoot = ($urandom_range(0, 11) == 0);
    if ($urandom_range(0, 29) == 0) loop_en = ~loop_en;
    if ($urandom_range(0, 399) == 0) begin
      rst = 1'b0;
      step_cyc();
      rst = 1'b1;
    end else begin
      step_cyc();
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [DIV_W-1:0] held_dl;

  initial begin
    rst = 1'b0;
    loop_en = 1'b0;
    idle_inputs();
    #1;
    cmp_en = 1'b1;
    step_cyc();
    step_cyc();
    check("rst_state", 64'(state), 64'd0);
    check("rst_step", 64'(step_idx), 64'd0);
    check("rst_div_left", 64'(div_left), 64'd0);
    check("rst_div_right", 64'(div_right), 64'd0);
    check("rst_sfx", 64'(sfx_active), 64'd0);
    rst = 1'b1;
    step_cyc();

    // play through once without looping
    start = 1'b1;
    step_cyc();
    start = 1'b0;
    check("start_play", 64'(state), 64'd1);
    step_cyc();
    check("step0_left", 64'(div_left), 64'd191571);
    check("step0_right_rest", 64'(div_right), 64'd0);
    repeat (3) step_cyc();
    check("beat1_idx", 64'(step_idx), 64'd1);
    step_cyc();
    check("step1_left", 64'(div_left), 64'd170648);
    repeat (3) step_cyc();
    check("beat2_idx", 64'(step_idx), 64'd2);
    step_cyc();
    check("step2_left", 64'(div_left), 64'd85034);
    check("step2_right", 64'(div_right), 64'd95420);
    repeat (3) step_cyc();
    check("done_state", 64'(state), 64'd3);
    check("done_idx", 64'(step_idx), 64'd2);
    step_cyc();
    check("done_left_silent", 64'(div_left), 64'd0);
    check("done_right_silent", 64'(div_right), 64'd0);

    // restart with looping
    loop_en = 1'b1;
    start = 1'b1;
    step_cyc();
    start = 1'b0;
    repeat (12) step_cyc();
    check("loop_idx_wrap", 64'(step_idx), 64'd0);
    check("loop_state", 64'(state), 64'd1);

    // pause at tick 2 of step 1, then resume
    repeat (6) step_cyc();
    pause = 1'b1;
    step_cyc();
    pause = 1'b0;
    check("pause_state", 64'(state), 64'd2);
    step_cyc();
    held_dl = div_left;
    repeat (9) step_cyc();
    check("pause_idx_frozen", 64'(step_idx), 64'd1);
    check("pause_left_held", 64'(div_left), 64'd170648);
    check("pause_left_stable", 64'(div_left), 64'(held_dl));
    check("pause_right_held", 64'(div_right), 64'd151515);
    start = 1'b1;
    step_cyc();
    start = 1'b0;
    step_cyc();
    check("resume_no_beat_yet", 64'(step_idx), 64'd1);
    step_cyc();
    check("resume_beat", 64'(step_idx), 64'd2);

    // stop and start together: stop wins
    stop = 1'b1;
    start = 1'b1;
    step_cyc();
    idle_inputs();
    loop_en = 1'b0;
    check("stop_wins_state", 64'(state), 64'd0);
    check("stop_wins_idx", 64'(step_idx), 64'd0);
    step_cyc();

    // shot effect while stopped
    sfx_shoot = 1'b1;
    step_cyc();
    sfx_shoot = 1'b0;
    check("shoot_active", 64'(sfx_active), 64'd1);
    repeat (4) step_cyc();
    check("shoot_active_5th", 64'(sfx_active), 64'd1);
    check("shoot_right", 64'(div_right), 64'd170648);
    check("shoot_left_quiet", 64'(div_left), 64'd0);
    step_cyc();
    check("shoot_expired", 64'(sfx_active), 64'd0);
    step_cyc();
    check("shoot_right_silent", 64'(div_right), 64'd0);

    // shot during die is dropped and does not extend
    sfx_die = 1'b1;
    step_cyc();
    sfx_die = 1'b0;
    step_cyc();
    sfx_shoot = 1'b1;
    step_cyc();
    sfx_shoot = 1'b0;
    check("die_holds_right", 64'(div_right), 64'd45086);
    repeat (3) step_cyc();
    check("die_not_reloaded", 64'(sfx_active), 64'd0);
    repeat (2) step_cyc();

    // die and shoot together -> die
    sfx_die = 1'b1;
    sfx_shoot = 1'b1;
    step_cyc();
    idle_inputs();
    step_cyc();
    check("both_pick_die", 64'(div_right), 64'd45086);
    repeat (6) step_cyc();

    // asynchronous reset mid-step with an active effect
    start = 1'b1;
    step_cyc();
    start = 1'b0;
    sfx_shoot = 1'b1;
    step_cyc();
    sfx_shoot = 1'b0;
    step_cyc();
    rst = 1'b0;
    #1;
    check("arst_state", 64'(state), 64'd0);
    check("arst_idx", 64'(step_idx), 64'd0);
    check("arst_left", 64'(div_left), 64'd0);
    check("arst_right", 64'(div_right), 64'd0);
    check("arst_sfx", 64'(sfx_active), 64'd0);
    repeat (2) step_cyc();
    rst = 1'b1;
    repeat (3) step_cyc();
    check("post_rst_sfx", 64'(sfx_active), 64'd0);
    check("post_rst_right", 64'(div_right), 64'd0);
    check("post_rst_state", 64'(state), 64'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) rand_cycle();
    idle_inputs();
    repeat (3) step_cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
